// File: rtl/mlcu_pkg.sv
// Shared types and helpers for the multi-lane sparse compute unit.
package mlcu_pkg;

  localparam int MAX_CHUNK = 256;
  localparam int IDX_W     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } lowest_t;

  // Number of set bits strictly below position p.
  function automatic logic [IDX_W-1:0] popcount_below(input logic [MAX_CHUNK-1:0] map,
                                                      input logic [IDX_W-1:0]     p);
    logic [IDX_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_CHUNK; i++) begin
      if (i < int'(p)) cnt = cnt + IDX_W'(map[i]);
    end
    return cnt;
  endfunction

  function automatic lowest_t lowest_set(input logic [MAX_CHUNK-1:0] map);
    lowest_t r;
    r = '0;
    for (int i = MAX_CHUNK - 1; i >= 0; i--) begin
      if (map[i]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mlcu_lane.sv
// One filter lane: filter buffer, remaining-match mask, operand fetch and a
// two-stage signed MAC into a private accumulator.
module mlcu_lane
  import mlcu_pkg::*;
#(
  parameter int CHUNK_SIZE = 64,
  parameter int BUS_SIZE   = 16,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int CW         = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [CW-1:0]              wr_count,
  input  logic [BUS_SIZE-1:0]        wr_map,
  input  logic [BUS_SIZE*DATA_W-1:0] wr_data,
  input  logic                       load,
  input  logic                       clear,
  input  logic                       run,
  input  logic [CHUNK_SIZE-1:0]      ifm_map,
  input  logic [CHUNK_SIZE-1:0]      ifm_map_nx,
  input  logic [DATA_W-1:0]          ifm_dat [CHUNK_SIZE],
  output logic                       empty_next,
  output logic [ACC_W-1:0]           acc
);

  localparam int AW = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;

  logic [CHUNK_SIZE-1:0]      fil_map, fil_map_nx, mask, mask_after;
  logic [DATA_W-1:0]          fil_dat [CHUNK_SIZE];
  lowest_t                    low;
  logic [IDX_W-1:0]           ifm_idx, fil_idx;
  logic [AW-1:0]              ifm_a, fil_a;
  logic                       issue, v1, v2;
  logic signed [DATA_W-1:0]   op_a, op_b;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  // A write on the start edge must already be part of the loaded mask.
  always_comb begin
    fil_map_nx = fil_map;
    if (wr_en) fil_map_nx[wr_count*BUS_SIZE +: BUS_SIZE] = wr_map;
  end

  assign low        = lowest_set(MAX_CHUNK'(mask));
  assign ifm_idx    = popcount_below(MAX_CHUNK'(ifm_map), low.idx);
  assign fil_idx    = popcount_below(MAX_CHUNK'(fil_map), low.idx);
  assign ifm_a      = AW'(ifm_idx);
  assign fil_a      = AW'(fil_idx);
  assign mask_after = mask & (mask - CHUNK_SIZE'(1));
  assign empty_next = (mask_after == '0);
  assign issue      = run && low.found;
  assign prod_ext   = prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fil_map <= '0;
      mask    <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      prod    <= '0;
      acc     <= '0;
    end else begin
      fil_map <= fil_map_nx;
      if (load)       mask <= ifm_map_nx & fil_map_nx;
      else if (issue) mask <= mask_after;
      v1 <= issue;
      if (issue) begin
        op_a <= ifm_dat[ifm_a];
        op_b <= fil_dat[fil_a];
      end
      v2 <= v1;
      if (v1) prod <= op_a * op_b;
      if (load && clear) acc <= '0;
      else if (v2)       acc <= acc + prod_ext;
    end
  end

  // Data buffer deliberately has no reset; only the map qualifies its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BUS_SIZE; i++)
        fil_dat[AW'(int'(wr_count) * BUS_SIZE + i)] <= wr_data[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/multi_lane_compute_unit.sv
// Broadcasts one compressed IFM chunk to LANES sparse MAC lanes; owns the IFM
// buffer, write decode and the IDLE/RUN/DRAIN/DONE sequencer.
module multi_lane_compute_unit
  import mlcu_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int CHUNK_SIZE = 64,
  parameter int BUS_SIZE   = 16,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int WR_CYC     = CHUNK_SIZE / BUS_SIZE,
  parameter int CW         = (WR_CYC > 1) ? $clog2(WR_CYC) : 1,
  parameter int LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ifm_wr_valid_i,
  input  logic [CW-1:0]              ifm_wr_count_i,
  input  logic [BUS_SIZE-1:0]        ifm_sparsemap_i,
  input  logic [BUS_SIZE*DATA_W-1:0] ifm_nonzero_data_i,
  input  logic                       fil_wr_valid_i,
  input  logic [LW-1:0]              fil_wr_lane_i,
  input  logic [CW-1:0]              fil_wr_count_i,
  input  logic [BUS_SIZE-1:0]        fil_sparsemap_i,
  input  logic [BUS_SIZE*DATA_W-1:0] fil_nonzero_data_i,
  input  logic                       start_i,
  input  logic                       acc_clear_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       acc_val_o,
  output logic [LANES*ACC_W-1:0]     acc_dat_o,
  output logic [1:0]                 state_o
);

  localparam int AW = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;

  state_t                state, state_nx;
  logic                  drain_cnt;
  logic                  ifm_we, fil_we, load, run, all_empty;
  logic [LANES-1:0]      lane_empty;
  logic [CHUNK_SIZE-1:0] ifm_map, ifm_map_nx;
  logic [DATA_W-1:0]     ifm_dat [CHUNK_SIZE];

  assign ifm_we = ifm_wr_valid_i && (state == IDLE);
  assign fil_we = fil_wr_valid_i && (state == IDLE);
  assign load   = start_i && (state == IDLE);
  assign run    = (state == RUN);

  always_comb begin
    ifm_map_nx = ifm_map;
    if (ifm_we) ifm_map_nx[ifm_wr_count_i*BUS_SIZE +: BUS_SIZE] = ifm_sparsemap_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ifm_map <= '0;
    else        ifm_map <= ifm_map_nx;
  end

  always_ff @(posedge clk_i) begin
    if (ifm_we) begin
      for (int i = 0; i < BUS_SIZE; i++)
        ifm_dat[AW'(int'(ifm_wr_count_i) * BUS_SIZE + i)] <= ifm_nonzero_data_i[i*DATA_W +: DATA_W];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mlcu_lane #(
      .CHUNK_SIZE (CHUNK_SIZE),
      .BUS_SIZE   (BUS_SIZE),
      .DATA_W     (DATA_W),
      .ACC_W      (ACC_W),
      .CW         (CW)
    ) u_lane (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .wr_en      (fil_we && (fil_wr_lane_i == LW'(l))),
      .wr_count   (fil_wr_count_i),
      .wr_map     (fil_sparsemap_i),
      .wr_data    (fil_nonzero_data_i),
      .load       (load),
      .clear      (acc_clear_i),
      .run        (run),
      .ifm_map    (ifm_map),
      .ifm_map_nx (ifm_map_nx),
      .ifm_dat    (ifm_dat),
      .empty_next (lane_empty[l]),
      .acc        (acc_dat_o[l*ACC_W +: ACC_W])
    );
  end

  assign all_empty = &lane_empty;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Two DRAIN cycles cover the operand and product stages.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i)   state_nx = RUN;
      RUN:     if (all_empty) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign acc_val_o = (state == DONE);
  assign state_o   = state;

endmodule

// File: tb/tb_multi_lane_compute_unit.sv
// Directed bench for multi_lane_compute_unit: expected results are queued at
// start time and checked by an independent monitor on each done pulse.
module tb_multi_lane_compute_unit;

  localparam int LANES = 4;
  localparam int ACC_W = 32;
  localparam int VW    = LANES * ACC_W;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          ifm_wr_valid_i;
  logic [1:0]    ifm_wr_count_i;
  logic [15:0]   ifm_sparsemap_i;
  logic [127:0]  ifm_nonzero_data_i;
  logic          fil_wr_valid_i;
  logic [1:0]    fil_wr_lane_i;
  logic [1:0]    fil_wr_count_i;
  logic [15:0]   fil_sparsemap_i;
  logic [127:0]  fil_nonzero_data_i;
  logic          start_i;
  logic          acc_clear_i;
  logic          busy_o;
  logic          done_o;
  logic          acc_val_o;
  logic [VW-1:0] acc_dat_o;
  logic [1:0]    state_o;

  multi_lane_compute_unit dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .ifm_wr_valid_i     (ifm_wr_valid_i),
    .ifm_wr_count_i     (ifm_wr_count_i),
    .ifm_sparsemap_i    (ifm_sparsemap_i),
    .ifm_nonzero_data_i (ifm_nonzero_data_i),
    .fil_wr_valid_i     (fil_wr_valid_i),
    .fil_wr_lane_i      (fil_wr_lane_i),
    .fil_wr_count_i     (fil_wr_count_i),
    .fil_sparsemap_i    (fil_sparsemap_i),
    .fil_nonzero_data_i (fil_nonzero_data_i),
    .start_i            (start_i),
    .acc_clear_i        (acc_clear_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .acc_val_o          (acc_val_o),
    .acc_dat_o          (acc_dat_o),
    .state_o            (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- reference state ----------------
  logic [63:0] m_ifm_map;
  logic [7:0]  m_ifm_dat [64];
  logic [63:0] m_fil_map [LANES];
  logic [7:0]  m_fil_dat [LANES][64];

  logic [VW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    logic [31:0]   a;
    int            ic, fc, x, y;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      a  = '0;
      ic = 0;
      fc = 0;
      for (int p = 0; p < 64; p++) begin
        if (m_ifm_map[p] && m_fil_map[l][p]) begin
          x = $signed(m_ifm_dat[ic]);
          y = $signed(m_fil_dat[l][fc]);
          a = a + 32'(x * y);
        end
        if (m_ifm_map[p])    ic++;
        if (m_fil_map[l][p]) fc++;
      end
      v[l*ACC_W +: ACC_W] = a;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_ifm(input int beat, input logic [15:0] map, input logic [127:0] data);
    ifm_wr_valid_i     = 1'b1;
    ifm_wr_count_i     = 2'(beat);
    ifm_sparsemap_i    = map;
    ifm_nonzero_data_i = data;
    m_ifm_map[beat*16 +: 16] = map;
    for (int e = 0; e < 16; e++) m_ifm_dat[beat*16 + e] = data[e*8 +: 8];
    @(negedge clk);
    ifm_wr_valid_i = 1'b0;
  endtask

  task automatic write_fil(input int lane, input int beat, input logic [15:0] map,
                           input logic [127:0] data);
    fil_wr_valid_i     = 1'b1;
    fil_wr_lane_i      = 2'(lane);
    fil_wr_count_i     = 2'(beat);
    fil_sparsemap_i    = map;
    fil_nonzero_data_i = data;
    m_fil_map[lane][beat*16 +: 16] = map;
    for (int e = 0; e < 16; e++) m_fil_dat[lane][beat*16 + e] = data[e*8 +: 8];
    @(negedge clk);
    fil_wr_valid_i = 1'b0;
  endtask

  // Start sampled on the next edge; done is expected in cycle k+3 after it.
  task automatic do_start(input bit clear, input bit push, input logic [VW-1:0] vec, input int k);
    if (push) begin
      exp_q.push_back(vec);
      exp_cyc_q.push_back(cyc + k + 3);
    end
    start_i     = 1'b1;
    acc_clear_i = clear;
    @(negedge clk);
    start_i     = 1'b0;
    acc_clear_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  // Lane0: 10 matches, lane1: 3, lane2/3: none.
  task automatic load_unequal();
    logic [127:0] d;
    logic [15:0]  m0 [4];
    logic [15:0]  m1 [4];
    m0 = '{16'h0155, 16'h001F, 16'h0000, 16'h0000};
    m1 = '{16'h0000, 16'h0000, 16'h8001, 16'h0100};
    for (int b = 0; b < 4; b++) begin
      for (int e = 0; e < 16; e++) d[e*8 +: 8] = 8'((b*16 + e) * 37 + 5);
      write_ifm(b, 16'hFFFF, d);
    end
    for (int b = 0; b < 4; b++) begin
      for (int e = 0; e < 16; e++) d[e*8 +: 8] = 8'((b*16 + e) * 29 + 186);
      write_fil(0, b, m0[b], d);
      for (int e = 0; e < 16; e++) d[e*8 +: 8] = 8'((b*16 + e) * 53 + 11);
      write_fil(1, b, m1[b], d);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [VW-1:0] mon_vec;
  int            mon_cyc;

  always @(negedge clk) begin
    if (rst_i === 1'b1 && done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_vec = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        for (int l = 0; l < LANES; l++)
          check($sformatf("acc_lane%0d", l), 64'(acc_dat_o[l*ACC_W +: ACC_W]),
                64'(mon_vec[l*ACC_W +: ACC_W]));
        check("done_cycle", 64'(cyc), 64'(mon_cyc));
        check("acc_val_with_done", 64'(acc_val_o), 64'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0]  d;
    logic [VW-1:0] v;

    rst_i = 1'b0;
    ifm_wr_valid_i = 1'b0; ifm_wr_count_i = '0; ifm_sparsemap_i = '0; ifm_nonzero_data_i = '0;
    fil_wr_valid_i = 1'b0; fil_wr_lane_i = '0; fil_wr_count_i = '0; fil_sparsemap_i = '0;
    fil_nonzero_data_i = '0; start_i = 1'b0; acc_clear_i = 1'b0;
    m_ifm_map = '0;
    for (int l = 0; l < LANES; l++) m_fil_map[l] = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_acc_val", 64'(acc_val_o), 64'd0);
    check("rst_acc_dat", 64'(acc_dat_o == '0), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);

    // Single match: ifm[3]=4, fil=2 -> 8 on lane0.
    for (int b = 0; b < 4; b++) begin
      for (int e = 0; e < 16; e++) d[e*8 +: 8] = 8'(b*16 + e + 1);
      write_ifm(b, 16'hFFFF, d);
    end
    d = '0; d[7:0] = 8'd2;
    write_fil(0, 0, 16'h0008, d);
    v = '0; v[31:0] = 32'd8;
    do_start(1'b1, 1'b1, v, 1);
    wait_done(20);

    // Empty intersection.
    for (int b = 0; b < 4; b++) write_ifm(b, 16'h0000, 128'd0);
    do_start(1'b1, 1'b1, '0, 1);
    wait_done(20);

    // Signed -128 * -128 on lane1, then accumulate without clear.
    d = '0; d[7:0] = 8'h80;
    write_ifm(0, 16'h0001, d);
    write_fil(1, 0, 16'h0001, d);
    v = '0; v[63:32] = 32'd16384;
    do_start(1'b1, 1'b1, v, 1);
    wait_done(20);
    v = '0; v[63:32] = 32'd32768;
    do_start(1'b0, 1'b1, v, 1);
    wait_done(20);

    // Unequal lane counts: done in cycle 13, busy over cycles 1..13.
    load_unequal();
    do_start(1'b1, 1'b1, model_vec(), 10);
    check("busy_c1", 64'(busy_o), 64'd1);
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", k), 64'(busy_o), 64'd1);
    end
    @(negedge clk);
    check("busy_c14", 64'(busy_o), 64'd0);

    // Write and restart during RUN are dropped.
    do_start(1'b1, 1'b1, model_vec(), 10);
    ifm_wr_valid_i     = 1'b1;
    ifm_wr_count_i     = 2'd0;
    ifm_sparsemap_i    = 16'h00FF;
    ifm_nonzero_data_i = {16{8'h7F}};
    start_i            = 1'b1;
    @(negedge clk);
    ifm_wr_valid_i = 1'b0;
    start_i        = 1'b0;
    wait_done(40);
    repeat (6) @(negedge clk);

    // Reset in RUN cycle 5, then reload and rerun.
    do_start(1'b1, 1'b0, '0, 10);
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_acc_val", 64'(acc_val_o), 64'd0);
    check("midrst_acc_dat", 64'(acc_dat_o == '0), 64'd1);
    m_ifm_map = '0;
    for (int l = 0; l < LANES; l++) m_fil_map[l] = '0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    load_unequal();
    do_start(1'b1, 1'b1, model_vec(), 10);
    wait_done(40);

    repeat (4) @(negedge clk);
    check("pending_expected", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
